// File: rtl/cache_update_arbiter.sv
// cache_update_arbiter
//   Round-robin arbiter that funnels NUM_REQ cache update requesters onto a
//   single registered cache update port. While an AXI read is waiting for
//   the shared cache read port (rd_pending), at most MAX_BURST consecutive
//   update beats are granted before a one-cycle READ_SLOT gap is inserted
//   so the read can get through.
//
//   Optional feature macro: UPDATE_ARB_STATS_EN
//     defined   -> per-requester 16-bit saturating grant counters readable
//                  through stat_sel / stat_count
//     undefined -> no counters, stat_count is constant zero
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ARB       | normal round-robin arbitration, one grant per cycle possible
//   READ_SLOT | one-cycle gap with no grants, leaves cache port to the read

module cache_update_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_data,
    input  logic                   rd_pending,
    output logic                   update_valid,
    output logic [31:0]            update_addr,
    output logic [31:0]            update_data,
    output logic [2:0]             grant_id,
    input  logic [2:0]             stat_sel,
    output logic [15:0]            stat_count
);

    typedef enum logic {
        ARB       = 1'b0,
        READ_SLOT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  last_grant;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_nxt;
    logic [2:0]  winner;
    logic        found;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;

    // Round-robin search: the valid requester closest after last_grant wins.
    // Offsets are scanned from farthest to nearest so the nearest one is the
    // last assignment and therefore takes priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (((int'(last_grant) + off) % NUM_REQ) == i)) begin
                    winner = 3'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    // One-hot ready and the winner's fields; ready is held low in reset and
    // during the read slot, and never looks at rd_pending.
    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && (state == ARB) && found && (winner == 3'(i))) begin
                req_ready[i] = 1'b1;
                sel_addr     = req_addr[32*i +: 32];
                sel_data     = req_data[32*i +: 32];
            end
        end
    end

    assign accept = |req_ready;

    // Next-state and burst counter: a full burst under a pending read forces
    // one READ_SLOT cycle; rd_pending low always clears the count.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            ARB: begin
                if (!rd_pending) begin
                    burst_nxt = '0;
                end else if (accept) begin
                    if ((burst_cnt + 8'd1) == 8'(MAX_BURST)) begin
                        burst_nxt = '0;
                        state_nxt = READ_SLOT;
                    end else begin
                        burst_nxt = burst_cnt + 8'd1;
                    end
                end
            end
            READ_SLOT: begin
                state_nxt = ARB;
                if (!rd_pending) begin
                    burst_nxt = '0;
                end
            end
            default: begin
                state_nxt = ARB;
                burst_nxt = '0;
            end
        endcase
    end

    // State, burst count and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            burst_cnt  <= '0;
            last_grant <= 3'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            if (accept) begin
                last_grant <= winner;
            end
        end
    end

    // Registered update port: strobe every accepted beat, hold fields otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_valid <= 1'b0;
            update_addr  <= '0;
            update_data  <= '0;
            grant_id     <= '0;
        end else begin
            update_valid <= accept;
            if (accept) begin
                update_addr <= sel_addr;
                update_data <= sel_data;
                grant_id    <= winner;
            end
        end
    end

`ifdef UPDATE_ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_REQ];

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (stat_cnt[i] != 16'hFFFF)) begin
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Statistics read mux; selects beyond NUM_REQ read zero.
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_count = stat_cnt[i];
            end
        end
    end
`else
    // stat_sel is masked to zero so it stays referenced; output is always 0.
    assign stat_count = {13'd0, stat_sel & 3'b000};
`endif

endmodule

// File: tb/tb_cache_update_arbiter.sv
// Testbench for cache_update_arbiter (NUM_REQ=4, MAX_BURST=8).
// Directed vector table, hand sequences for burst/slot/reset corners, and
// randomized traffic checked against a cycle-level reference model.

module tb_cache_update_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_addr = '0;
    logic [N*32-1:0] req_data = '0;
    logic            rd_pending = 1'b0;
    logic            update_valid;
    logic [31:0]     update_addr;
    logic [31:0]     update_data;
    logic [2:0]      grant_id;
    logic [2:0]      stat_sel = '0;
    logic [15:0]     stat_count;

    cache_update_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rd_pending   (rd_pending),
        .update_valid (update_valid),
        .update_addr  (update_addr),
        .update_data  (update_data),
        .grant_id     (grant_id),
        .stat_sel     (stat_sel),
        .stat_count   (stat_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] a [N];
    logic [31:0] d [N];

    // reference model state
    int          m_lg;
    int          m_burst;
    bit          m_slot;
    bit          m_uv;
    logic [31:0] m_ua;
    logic [31:0] m_ud;
    int          m_gid;
    int          m_stat [N];

    logic [N-1:0] obs_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lg = N - 1; m_burst = 0; m_slot = 0;
        m_uv = 0; m_ua = '0; m_ud = '0; m_gid = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endtask

    function automatic int exp_stat(input int sel);
`ifdef UPDATE_ARB_STATS_EN
        return (sel < N) ? m_stat[sel] : 0;
`else
        return 0;
`endif
    endfunction

    // One clock cycle: check ready/stats mid-cycle, then registered outputs.
    task automatic step();
        int w;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = a[i];
            req_data[32*i +: 32] = d[i];
        end
        @(negedge clk);
        w = -1;
        if (!m_slot) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && req_valid[(m_lg + k) % N]) w = (m_lg + k) % N;
            end
        end
        er = (w >= 0) ? N'(1 << w) : '0;
        obs_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("stat_count", 32'(stat_count), 32'(exp_stat(int'(stat_sel))));
        @(posedge clk); #1;
        if (m_slot) begin
            m_slot = 0;
            if (!rd_pending) m_burst = 0;
        end else if (!rd_pending) begin
            m_burst = 0;
        end else if (w >= 0) begin
            m_burst++;
            if (m_burst == MB) begin m_slot = 1; m_burst = 0; end
        end
        if (w >= 0) begin
            m_uv = 1; m_ua = a[w]; m_ud = d[w]; m_gid = w; m_lg = w;
            if (m_stat[w] < 65535) m_stat[w]++;
        end else begin
            m_uv = 0;
        end
        chk("update_valid", 32'(update_valid), 32'(m_uv));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("update_addr", update_addr, m_ua);
        chk("update_data", update_data, m_ud);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_uv", 32'(update_valid), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gid", 32'(grant_id), 32'd0);
        chk("reset_addr", update_addr, 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         rd;
        logic [N-1:0] exp_ready;
        logic         exp_uv;
        logic [2:0]   exp_gid;
    } vec_t;

    vec_t tbl [12];
    int   beats;

    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = 32'h0000_1000 * (i + 1);
            d[i] = 32'hC0DE_0000 + i;
        end
        a[2] = 32'h0000_0010;
        d[2] = 32'hDEAD_BEEF;

        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3'd0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 3'd1};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3'd2};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd3};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 3'd0};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 3'd1};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3'd2};
        tbl[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3'd3};
        tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 3'd2};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3'd2};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd2};
        tbl[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 3'd0};

        // directed table from reset
        do_reset();
        for (int v = 0; v < 12; v++) begin
            req_valid  = tbl[v].valid;
            rd_pending = tbl[v].rd;
            step();
            chk($sformatf("tbl%0d_ready", v), 32'(obs_ready), 32'(tbl[v].exp_ready));
            chk($sformatf("tbl%0d_uv", v), 32'(update_valid), 32'(tbl[v].exp_uv));
            chk($sformatf("tbl%0d_gid", v), 32'(grant_id), 32'(tbl[v].exp_gid));
            chk($sformatf("tbl%0d_addr", v), update_addr, a[tbl[v].exp_gid]);
        end

        // fields of a non-granted requester are not sampled
        req_valid = '0; rd_pending = 1'b0;
        a[0] = 32'h0000_0999;
        step();
        chk("hold_addr", update_addr, 32'h0000_1000);
        a[0] = 32'h0000_1000;

        // full burst under pending read, one gap, resume round-robin
        do_reset();
        req_valid = '1; rd_pending = 1'b1;
        for (int i = 0; i < MB; i++) step();
        step();
        chk("slot_gap_uv", 32'(update_valid), 32'd0);
        chk("slot_gap_ready", 32'(obs_ready), 32'd0);
        step();
        chk("resume_gid", 32'(grant_id), 32'd0);
        chk("resume_uv", 32'(update_valid), 32'd1);

        // rd_pending pulse after 5 grants restarts the burst count
        do_reset();
        req_valid = '1; rd_pending = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd_pending = 1'b0;
        step();
        rd_pending = 1'b1;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!update_valid) break;
            beats++;
        end
        chk("beats_after_pulse", 32'(beats), 32'(MB));

        // reset asserted during the read slot
        do_reset();
        req_valid = '1; rd_pending = 1'b1;
        for (int i = 0; i < MB; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("slot_reset_uv", 32'(update_valid), 32'd0);
        chk("slot_reset_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();
        chk("post_reset_gid", 32'(grant_id), 32'd0);

        // grant statistics
        do_reset();
        req_valid = 4'b0010; rd_pending = 1'b0;
        for (int i = 0; i < 12; i++) step();
        req_valid = '0;
        stat_sel = 3'd1;
        #1;
`ifdef UPDATE_ARB_STATS_EN
        chk("stat_req1", 32'(stat_count), 32'd12);
`else
        chk("stat_req1", 32'(stat_count), 32'd0);
`endif
        stat_sel = 3'd7;
        #1;
        chk("stat_sel7", 32'(stat_count), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid  = N'($urandom_range(0, (1 << N) - 1));
            rd_pending = ($urandom_range(0, 3) != 0);
            stat_sel   = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                a[i] = $urandom;
                d[i] = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_update_arbiter.md
CACHE_UPDATE_ARBITER -- requirements
Module: cache_update_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of update requesters, legal range 2..8.
REQ-002 Parameter MAX_BURST, default 8: maximum consecutive update grants while a read is pending, legal range 1..255.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  NUM_REQ  per-requester update request.
REQ-006 Port req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-007 Port req_addr  input  NUM_REQ*32  packed addresses; requester i at bits [32i+31:32i].
REQ-008 Port req_data  input  NUM_REQ*32  packed data, same packing as req_addr.
REQ-009 Port rd_pending  input  1  AXI read address handshake waiting for the shared cache read port (driven from arvalid).
REQ-010 Port update_valid  output  1  registered write strobe to the cache update port.
REQ-011 Port update_addr  output  32  registered cache update address.
REQ-012 Port update_data  output  32  registered cache update data.
REQ-013 Port grant_id  output  3  registered index of the requester driving the current update beat.
REQ-014 Port stat_sel  input  3  requester select for grant statistics.
REQ-015 Port stat_count  output  16  grant count of requester stat_sel.

Function
REQ-016 The state machine SHALL have two states: ARB, which grants normally, and READ_SLOT, which grants nothing.
REQ-017 In ARB with at least one req_valid set, the block SHALL assert req_ready combinationally for exactly one requester.
- The winner is the first valid index after last_grant, searching round-robin with wrap from NUM_REQ-1 to 0.
REQ-018 On the accept edge (req_valid[i] && req_ready[i]), the block SHALL register the following, giving one-cycle latency:
- update_valid <= 1.
- update_addr and update_data <= requester i's fields.
- grant_id <= i.
- last_grant <= i.
REQ-019 On a cycle with no accept, update_valid SHALL be 0 on the next cycle; update_addr, update_data and grant_id SHALL hold their values.
REQ-020 A requester that holds req_valid SHALL be granted within NUM_REQ accepted beats (no starvation).
REQ-021 A burst counter burst_cnt SHALL increment on each accept while rd_pending=1, and SHALL clear to 0 on any cycle with rd_pending=0.
REQ-022 When an accept makes burst_cnt reach MAX_BURST, the next state SHALL be READ_SLOT and burst_cnt SHALL clear.
REQ-023 In READ_SLOT, req_ready SHALL be all zero, update_valid SHALL be 0 on the following cycle, and the state SHALL return to ARB after exactly one cycle.
REQ-024 With rd_pending=0, the block SHALL never enter READ_SLOT, and back-to-back grants SHALL be sustained every cycle.
REQ-025 If rd_pending falls during READ_SLOT, the slot SHALL still complete its one cycle.
REQ-026 Requester fields SHALL be sampled only on the accept edge; changes to req_addr or req_data while req_ready=0 SHALL have no effect.
REQ-027 req_ready SHALL depend only on state, last_grant and req_valid, never on rd_pending in the same cycle.

Reset
REQ-028 On rst_n low, the block SHALL immediately and asynchronously set the following:
- state=ARB, burst_cnt=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
- update_valid=0, update_addr=0, update_data=0, grant_id=0.
- All statistics counters to 0.
REQ-029 While rst_n is low, req_ready SHALL be all zero.
REQ-030 A reset asserted mid-burst or during READ_SLOT SHALL discard the in-flight beat; the first cycle after deassertion SHALL arbitrate from reset state.

Configuration
REQ-031 Macro UPDATE_ARB_STATS_EN, when defined, SHALL compile in NUM_REQ 16-bit counters.
- Each counter increments on its requester's accept and saturates at 0xFFFF.
- stat_count SHALL equal the counter for stat_sel combinationally; stat_sel >= NUM_REQ SHALL read 0.
REQ-032 Without UPDATE_ARB_STATS_EN, no counters SHALL exist, stat_count SHALL be constant 0, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset release, then req_valid=4'b1111 held for 8 cycles, rd_pending=0 -> grant_id sequence 0,1,2,3,0,1,2,3 and update_valid=1 every cycle from cycle 2.
REQ-034 Only req 2 valid, addr=0x10, data=0xDEADBEEF -> next cycle update_valid=1, update_addr=0x10, update_data=0xDEADBEEF, grant_id=2; after req 2 drops, update_valid=0.
REQ-035 MAX_BURST=8, rd_pending=1, all requesters valid -> 8 update beats, one cycle with update_valid=0, then grants resume at the next round-robin index.
REQ-036 rd_pending pulses low for 1 cycle after 5 grants -> burst_cnt clears and 8 further beats precede the READ_SLOT gap.
REQ-037 rst_n asserted while READ_SLOT is active -> update_valid=0 immediately; after release, all valid -> requester 0 granted first.
REQ-038 With UPDATE_ARB_STATS_EN, 12 grants to requester 1 -> stat_sel=1 gives stat_count=12 and stat_sel=7 gives 0; without the macro, stat_count=0 throughout.
